core_ex_mc: RTL and testbench
=============================

Name: core_ex_mc

Overview:
- Parametrised, registered successor of the combinational execute stage.
- Resolves ALU write-back, branches and JAL/JALR in one cycle.
- Adds iterative RV32M multiply/divide through a multi-cycle FSM that raises hold_flag_out to stall the pipeline.
- Sits between core_id and core_regs/core_ctrl; write-back outputs are registered (EX/WB boundary).

Parameters:
XLEN, 32, datapath and address width
REG_AW, 5, register-file address width
BITS_PER_CYCLE, 1, quotient/product bits resolved per MD iteration; must be 1, 2 or 4
MD_CYCLES, XLEN/BITS_PER_CYCLE, derived localparam; iteration count

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
valid_in  in  1  ID/EX slot holds a real instruction
flush_in  in  1  core_ctrl kill; aborts current instruction
inst_addr_in  in  XLEN  instruction address
opcode_in  in  7  opcode
func3_in  in  3  func3
func7_in  in  7  func7
func_in  in  ALUFuncBus  ALU function from ID
eval_val_in  in  XLEN  ALU result / compare code / link value
reg_we_in  in  1  write-enable request
reg_write_addr_in  in  REG_AW  rd
reg1_data_in  in  XLEN  rs1 value
reg2_data_in  in  XLEN  rs2 value
immI_in  in  XLEN  I immediate, sign-extended
immB_in  in  XLEN  B immediate, sign-extended
immJ_in  in  XLEN  J immediate, sign-extended
reg_we_out  out  1  registered write enable
reg_write_addr_out  out  REG_AW  registered rd
reg_write_data_out  out  XLEN  registered write data
hold_flag_out  out  1  stall request to core_ctrl
jump_flag_out  out  1  redirect, combinational
jump_addr_out  out  XLEN  redirect target, combinational
md_busy_out  out  1  FSM not IDLE

Behaviour:
- Reset: all registered outputs 0. FSM=IDLE. hold_flag_out=0, md_busy_out=0.
- Reset and flush mid-operation: either event in any state forces IDLE next edge and discards partial results; reg_we_out=0 that cycle.
- Simple ops (valid_in, not MD):
  - Outputs register at next edge (1-cycle latency).
  - I/R ALU funcs ADD..SLTU write eval_val_in. Any other func writes 0.
  - JAL/JALR write eval_val_in (link). Everything else writes 0.
  - reg_we_out = reg_we_in & valid_in & ~flush_in & (rd!=0).
- Jumps (combinational, gated by valid_in & ~flush_in & FSM==IDLE):
  - B-type taken per func3 vs compare code (CMP_EQ/LT/GT) → target inst_addr+immB.
  - JAL → target inst_addr+immJ.
  - JALR → target (reg1+immI)&~1.
  - Sums wrap modulo 2^XLEN.
  - Not taken: jump_flag_out=0, jump_addr_out=CPURstAddress.
- MD ops: opcode R-type, func7=0000001.
  - FSM IDLE→CALC on accept, latching operands, func3 and rd.
  - CALC runs MD_CYCLES iterations: shift-add multiply, restoring divide, BITS_PER_CYCLE bits each.
  - CALC→DONE after the last iteration. DONE→IDLE next cycle, registering the result with reg_we_out per the rule above.
  - hold_flag_out=1 combinationally from the accept cycle through the CALC cycles. It is 0 in DONE.
  - Total latency: accept to write-back = MD_CYCLES+2 edges.
  - valid_in while FSM≠IDLE is ignored. core_ctrl keeps the ID/EX inputs stable while held.
- MD arithmetic:
  - Signed ops take magnitudes and fix the sign at the end. MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits of the signed×signed, signed×unsigned and unsigned×unsigned product respectively.
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder 0, both in 1 cycle (skip CALC).
  - DIV/DIVU/REM/REMU select the quotient or remainder.
- Simultaneous events:
  - flush_in with an MD accept → no accept.
  - rst has priority over flush_in, which has priority over everything else.

Decomposition:
- Shared package/defines.v: ALUFunc codes, CMP_* codes, INST_TYPE_*, INST_FUNC3_* for branches and M ops, FUNC7_MULDIV, ZeroWord, CPURstAddress, JumpEnable/Disable, HoldEnable/None.
- One sub-module, core_ex_muldiv:
  - Holds the FSM, operand and accumulator registers, and the iteration counter.
  - Handshake: start/func3/a/b in, busy/done/result out.
- core_ex_mc keeps the jump logic and the write-back register.

Test Plan:
- ADD, eval_val_in=0x0000_0010, rd=5 → next edge reg_we_out=1, addr=5, data=0x10. With rd=0 → reg_we_out=0.
- BEQ, inst_addr=0x100, immB=−8, eval=CMP_EQ → same cycle jump_flag_out=1, jump_addr_out=0xF8. With CMP_LT → jump_flag_out=0, jump_addr_out=CPURstAddress.
- MUL 0xFFFF_FFFF×3, then MULHU on the same operands, BITS_PER_CYCLE=1 → hold_flag_out high 33 cycles; results 0xFFFF_FFFD and 0x0000_0002 at cycle 34.
- Divide corner cases:
  - DIV 7/0 → data 0xFFFF_FFFF.
  - REM 7/0 → 7.
  - DIV 0x8000_0000/−1 → 0x8000_0000, no CALC cycles.
  - DIV −7/2 → 0xFFFF_FFFD.
  - REM −7/2 → 0xFFFF_FFFF.
- flush_in asserted at CALC iteration 10 → next edge IDLE, hold_flag_out=0, no write. A following ADD completes normally.
- rst asserted mid-CALC and JALR with reg1=0x1001, immI=2 → all outputs 0 after reset. After release, JALR target 0x1002, link eval_val_in written.

Source files
------------

// File: rtl/core_ex_mc_pkg.sv
// rtl/core_ex_mc_pkg.sv - shared codes and constants for the registered execute stage
package core_ex_mc_pkg;

  // ALU function codes from core_id; ADD..SLTU are contiguous so a range test selects them
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_NONE = 4'd15
  } alu_func_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Compare codes carried on eval_val_in for branches
  localparam int CMP_EQ = 1;
  localparam int CMP_LT = 2;
  localparam int CMP_GT = 4;

  localparam logic [6:0] INST_TYPE_I = 7'b0010011;
  localparam logic [6:0] INST_TYPE_R = 7'b0110011;
  localparam logic [6:0] INST_TYPE_B = 7'b1100011;
  localparam logic [6:0] INST_JAL    = 7'b1101111;
  localparam logic [6:0] INST_JALR   = 7'b1100111;

  localparam logic [2:0] INST_FUNC3_BEQ  = 3'b000;
  localparam logic [2:0] INST_FUNC3_BNE  = 3'b001;
  localparam logic [2:0] INST_FUNC3_BLT  = 3'b100;
  localparam logic [2:0] INST_FUNC3_BGE  = 3'b101;
  localparam logic [2:0] INST_FUNC3_BLTU = 3'b110;
  localparam logic [2:0] INST_FUNC3_BGEU = 3'b111;

  localparam logic [2:0] INST_FUNC3_MUL    = 3'b000;
  localparam logic [2:0] INST_FUNC3_MULH   = 3'b001;
  localparam logic [2:0] INST_FUNC3_MULHSU = 3'b010;
  localparam logic [2:0] INST_FUNC3_MULHU  = 3'b011;
  localparam logic [2:0] INST_FUNC3_DIV    = 3'b100;
  localparam logic [2:0] INST_FUNC3_DIVU   = 3'b101;
  localparam logic [2:0] INST_FUNC3_REM    = 3'b110;
  localparam logic [2:0] INST_FUNC3_REMU   = 3'b111;

  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
  localparam logic [31:0] CPU_RST_ADDRESS = 32'h0000_0000;
  localparam logic        JUMP_ENABLE     = 1'b1;
  localparam logic        JUMP_DISABLE    = 1'b0;
  localparam logic        HOLD_ENABLE     = 1'b1;
  localparam logic        HOLD_NONE       = 1'b0;

endpackage

// File: rtl/core_ex_mc_muldiv.sv
// rtl/core_ex_mc_muldiv.sv - iterative RV32M multiply/divide unit
// Ports: clk, rst (sync, active-high), kill (abort to IDLE), start/func3/a/b (operation request),
//        busy (FSM not IDLE), done (FSM in DONE, result valid), result (selected MD result).
module core_ex_muldiv
  import core_ex_mc_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int MD_CYCLES = XLEN / BITS_PER_CYCLE;
  localparam int CW        = $clog2(MD_CYCLES + 1);

  md_state_e       state, state_next;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic [XLEN-1:0] op_b;
  // Multiply: {acc_hi, acc_lo} = {partial product, remaining multiplier bits}
  // Divide:   acc_hi = partial remainder, acc_lo = dividend bits shifting out / quotient bits shifting in
  logic [XLEN-1:0] acc_hi, acc_lo;
  logic            neg_a, neg_b, b_zero;

  logic            signed_a, signed_b, sa, sb, overflow;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    signed_a = (func3 == INST_FUNC3_MULH) || (func3 == INST_FUNC3_MULHSU) ||
               (func3 == INST_FUNC3_DIV)  || (func3 == INST_FUNC3_REM);
    signed_b = (func3 == INST_FUNC3_MULH) || (func3 == INST_FUNC3_DIV) ||
               (func3 == INST_FUNC3_REM);
    sa       = signed_a & a[XLEN-1];
    sb       = signed_b & b[XLEN-1];
    mag_a    = sa ? -a : a;
    mag_b    = sb ? -b : b;
    overflow = ((func3 == INST_FUNC3_DIV) || (func3 == INST_FUNC3_REM)) &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (start) state_next = overflow ? MD_DONE : MD_CALC;
      MD_CALC: if (cnt == CW'(MD_CYCLES - 1)) state_next = MD_DONE;
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
    if (kill) state_next = MD_IDLE;
  end

  // One iteration step of both algorithms; the op latched at start picks which one is kept
  logic [XLEN+BITS_PER_CYCLE-1:0] mul_sum, mul_add;
  logic [XLEN:0]                  div_trial;
  logic [XLEN-1:0]                div_rem, div_quo;

  always_comb begin
    mul_add = {{BITS_PER_CYCLE{1'b0}}, op_b};
    mul_sum = {{BITS_PER_CYCLE{1'b0}}, acc_hi};
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (acc_lo[j]) mul_sum = mul_sum + (mul_add << j);
    end
    div_rem   = acc_hi;
    div_quo   = acc_lo;
    div_trial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      div_trial = {div_rem, div_quo[XLEN-1]};
      div_quo   = {div_quo[XLEN-2:0], 1'b0};
      if (div_trial >= {1'b0, op_b}) begin
        div_trial  = div_trial - {1'b0, op_b};
        div_quo[0] = 1'b1;
      end
      div_rem = div_trial[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= '0;
      op_b   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
    end else if ((state == MD_IDLE) && start && !kill) begin
      cnt    <= '0;
      op_q   <= func3;
      op_b   <= mag_b;
      acc_hi <= '0;
      // Overflow case bypasses the iterations: quotient = dividend, remainder = 0, no sign fix
      acc_lo <= overflow ? a : mag_a;
      neg_a  <= sa & ~overflow;
      neg_b  <= sb & ~overflow;
      b_zero <= (b == '0);
    end else if (state == MD_CALC) begin
      cnt <= cnt + 1'b1;
      if (op_q[2]) begin
        acc_hi <= div_rem;
        acc_lo <= div_quo;
      end else begin
        acc_hi <= mul_sum[XLEN+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
        acc_lo <= {mul_sum[BITS_PER_CYCLE-1:0], acc_lo[XLEN-1:BITS_PER_CYCLE]};
      end
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    prod = {acc_hi, acc_lo};
    if (neg_a ^ neg_b) prod = -prod;
    // Divide by zero keeps the all-ones quotient regardless of dividend sign
    quo    = ((neg_a ^ neg_b) && !b_zero) ? -acc_lo : acc_lo;
    rem    = neg_a ? -acc_hi : acc_hi;
    result = '0;
    case (op_q)
      INST_FUNC3_MUL:                                       result = prod[XLEN-1:0];
      INST_FUNC3_MULH, INST_FUNC3_MULHSU, INST_FUNC3_MULHU: result = prod[2*XLEN-1:XLEN];
      INST_FUNC3_DIV, INST_FUNC3_DIVU:                      result = quo;
      default:                                              result = rem;
    endcase
  end

  assign busy = (state != MD_IDLE);
  assign done = (state == MD_DONE);

endmodule

// File: rtl/core_ex_mc.sv
// rtl/core_ex_mc.sv - registered execute stage with jump resolution and multi-cycle RV32M
// Ports: clk, rst (sync, active-high); ID/EX inputs (valid_in, flush_in, inst_addr_in, opcode_in,
//        func3_in, func7_in, func_in, eval_val_in, reg_we_in, reg_write_addr_in, reg1/reg2_data_in,
//        immI/immB/immJ_in); registered write-back (reg_we_out, reg_write_addr_out, reg_write_data_out);
//        combinational hold_flag_out, jump_flag_out, jump_addr_out; md_busy_out.
module core_ex_mc
  import core_ex_mc_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_AW         = 5,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              flush_in,
  input  logic [XLEN-1:0]   inst_addr_in,
  input  logic [6:0]        opcode_in,
  input  logic [2:0]        func3_in,
  input  logic [6:0]        func7_in,
  input  alu_func_e         func_in,
  input  logic [XLEN-1:0]   eval_val_in,
  input  logic              reg_we_in,
  input  logic [REG_AW-1:0] reg_write_addr_in,
  input  logic [XLEN-1:0]   reg1_data_in,
  input  logic [XLEN-1:0]   reg2_data_in,
  input  logic [XLEN-1:0]   immI_in,
  input  logic [XLEN-1:0]   immB_in,
  input  logic [XLEN-1:0]   immJ_in,
  output logic              reg_we_out,
  output logic [REG_AW-1:0] reg_write_addr_out,
  output logic [XLEN-1:0]   reg_write_data_out,
  output logic              hold_flag_out,
  output logic              jump_flag_out,
  output logic [XLEN-1:0]   jump_addr_out,
  output logic              md_busy_out
);

  logic              is_md, md_start, md_busy, md_done, simple_ok;
  logic [XLEN-1:0]   md_result, simple_data;
  logic [REG_AW-1:0] md_rd_q;
  logic              md_we_q;

  assign is_md     = (opcode_in == INST_TYPE_R) && (func7_in == FUNC7_MULDIV);
  assign md_start  = valid_in & ~flush_in & is_md & ~md_busy;
  assign simple_ok = valid_in & ~md_busy & ~is_md;

  core_ex_muldiv #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .kill   (flush_in),
    .start  (md_start),
    .func3  (func3_in),
    .a      (reg1_data_in),
    .b      (reg2_data_in),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // Stall from the accept cycle through the last iteration; DONE lets the pipeline move
  assign hold_flag_out = (md_start | (md_busy & ~md_done)) ? HOLD_ENABLE : HOLD_NONE;
  assign md_busy_out   = md_busy;

  logic cmp_eq, cmp_lt, branch_taken;

  always_comb begin
    cmp_eq       = (eval_val_in == XLEN'(CMP_EQ));
    cmp_lt       = (eval_val_in == XLEN'(CMP_LT));
    branch_taken = 1'b0;
    case (func3_in)
      INST_FUNC3_BEQ:                  branch_taken = cmp_eq;
      INST_FUNC3_BNE:                  branch_taken = ~cmp_eq;
      INST_FUNC3_BLT, INST_FUNC3_BLTU: branch_taken = cmp_lt;
      INST_FUNC3_BGE, INST_FUNC3_BGEU: branch_taken = ~cmp_lt;
      default:                         branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    jump_flag_out = JUMP_DISABLE;
    jump_addr_out = XLEN'(CPU_RST_ADDRESS);
    if (valid_in && !flush_in && !md_busy) begin
      case (opcode_in)
        INST_TYPE_B: if (branch_taken) begin
          jump_flag_out = JUMP_ENABLE;
          jump_addr_out = inst_addr_in + immB_in;
        end
        INST_JAL: begin
          jump_flag_out = JUMP_ENABLE;
          jump_addr_out = inst_addr_in + immJ_in;
        end
        INST_JALR: begin
          jump_flag_out = JUMP_ENABLE;
          jump_addr_out = (reg1_data_in + immI_in) & {{(XLEN-1){1'b1}}, 1'b0};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    simple_data = XLEN'(ZERO_WORD);
    if (((opcode_in == INST_TYPE_I) || (opcode_in == INST_TYPE_R)) && (func_in <= ALU_SLTU))
      simple_data = eval_val_in;
    else if ((opcode_in == INST_JAL) || (opcode_in == INST_JALR))
      simple_data = eval_val_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_rd_q <= '0;
      md_we_q <= 1'b0;
    end else if (md_start) begin
      md_rd_q <= reg_write_addr_in;
      md_we_q <= reg_we_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_in) begin
      reg_we_out         <= 1'b0;
      reg_write_addr_out <= '0;
      reg_write_data_out <= '0;
    end else if (md_done) begin
      reg_we_out         <= md_we_q & (md_rd_q != '0);
      reg_write_addr_out <= md_rd_q;
      reg_write_data_out <= md_result;
    end else if (simple_ok) begin
      reg_we_out         <= reg_we_in & (reg_write_addr_in != '0);
      reg_write_addr_out <= reg_write_addr_in;
      reg_write_data_out <= simple_data;
    end else begin
      reg_we_out         <= 1'b0;
      reg_write_addr_out <= '0;
      reg_write_data_out <= '0;
    end
  end

endmodule

// File: tb/tb_core_ex_mc.sv
// tb/tb_core_ex_mc.sv - self-checking bench for core_ex_mc
module tb_core_ex_mc;
  import core_ex_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, flush_in, reg_we_in;
  logic [31:0] inst_addr_in, eval_val_in, reg1_data_in, reg2_data_in;
  logic [31:0] immI_in, immB_in, immJ_in;
  logic [6:0]  opcode_in, func7_in;
  logic [2:0]  func3_in;
  alu_func_e   func_in;
  logic [4:0]  reg_write_addr_in;
  logic        reg_we_out, hold_flag_out, jump_flag_out, md_busy_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] reg_write_data_out, jump_addr_out;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  core_ex_mc #(.XLEN(32), .REG_AW(5), .BITS_PER_CYCLE(1)) dut (
    .clk                (clk),
    .rst                (rst),
    .valid_in           (valid_in),
    .flush_in           (flush_in),
    .inst_addr_in       (inst_addr_in),
    .opcode_in          (opcode_in),
    .func3_in           (func3_in),
    .func7_in           (func7_in),
    .func_in            (func_in),
    .eval_val_in        (eval_val_in),
    .reg_we_in          (reg_we_in),
    .reg_write_addr_in  (reg_write_addr_in),
    .reg1_data_in       (reg1_data_in),
    .reg2_data_in       (reg2_data_in),
    .immI_in            (immI_in),
    .immB_in            (immB_in),
    .immJ_in            (immJ_in),
    .reg_we_out         (reg_we_out),
    .reg_write_addr_out (reg_write_addr_out),
    .reg_write_data_out (reg_write_data_out),
    .hold_flag_out      (hold_flag_out),
    .jump_flag_out      (jump_flag_out),
    .jump_addr_out      (jump_addr_out),
    .md_busy_out        (md_busy_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [4:0] addr, input logic [31:0] data);
    wb_t e;
    e.we = we; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_wb(input string tag);
    wb_t e;
    e = exp_q.pop_front();
    chk({tag, " we"}, 32'(reg_we_out), 32'(e.we));
    if (e.we) begin
      chk({tag, " addr"}, 32'(reg_write_addr_out), 32'(e.addr));
      chk({tag, " data"}, reg_write_data_out, e.data);
    end
  endtask

  task automatic clear_inputs();
    valid_in = 0; flush_in = 0; reg_we_in = 0; inst_addr_in = 0; eval_val_in = 0;
    reg1_data_in = 0; reg2_data_in = 0; immI_in = 0; immB_in = 0; immJ_in = 0;
    opcode_in = 0; func7_in = 0; func3_in = 0; func_in = ALU_NONE; reg_write_addr_in = 0;
  endtask

  task automatic drive_alu(input logic [6:0] op, input alu_func_e f, input logic [31:0] ev,
                           input logic [4:0] rd, input logic we);
    clear_inputs();
    valid_in = 1; opcode_in = op; func_in = f; eval_val_in = ev;
    reg_write_addr_in = rd; reg_we_in = we;
  endtask

  task automatic drive_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    clear_inputs();
    valid_in = 1; opcode_in = INST_TYPE_R; func7_in = FUNC7_MULDIV; func3_in = f3;
    reg1_data_in = a; reg2_data_in = b; reg_write_addr_in = rd; reg_we_in = 1;
  endtask

  task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expd, input int exp_edges);
    int   edges, holds;
    logic seen;
    drive_md(f3, a, b, 5'd10);
    #1;
    push(1'b1, 5'd10, expd);
    edges = 0; holds = 0; seen = 0;
    while (!seen && edges < 100) begin
      if (hold_flag_out) holds++;
      tick();
      edges++;
      if (reg_we_out) seen = 1;
    end
    clear_inputs();
    chk({tag, " seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, edges, exp_edges);
    chk({tag, " hold cycles"}, holds, exp_edges - 1);
    check_wb(tag);
  endtask

  initial begin
    int writes;
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst we", 32'(reg_we_out), 0);
    chk("rst addr", 32'(reg_write_addr_out), 0);
    chk("rst data", reg_write_data_out, 0);
    chk("rst hold", 32'(hold_flag_out), 0);
    chk("rst busy", 32'(md_busy_out), 0);
    chk("rst jflag", 32'(jump_flag_out), 0);
    chk("rst jaddr", jump_addr_out, CPU_RST_ADDRESS);
    rst = 0;

    drive_alu(INST_TYPE_I, ALU_ADD, 32'h10, 5'd5, 1'b1);  push(1, 5, 32'h10); tick(); check_wb("add rd5");
    drive_alu(INST_TYPE_I, ALU_ADD, 32'h10, 5'd0, 1'b1);  push(0, 0, 0);      tick(); check_wb("add rd0");
    drive_alu(INST_TYPE_R, ALU_SLTU, 32'h1, 5'd4, 1'b1);  push(1, 4, 32'h1);  tick(); check_wb("sltu");
    drive_alu(INST_TYPE_I, ALU_NONE, 32'hDEAD, 5'd3, 1'b1); push(1, 3, 0);    tick(); check_wb("nonalu");
    drive_alu(INST_TYPE_R, ALU_XOR, 32'h55, 5'd9, 1'b0);  push(0, 0, 0);      tick(); check_wb("we off");

    clear_inputs();
    valid_in = 1; opcode_in = INST_TYPE_B; func3_in = INST_FUNC3_BEQ;
    inst_addr_in = 32'h100; immB_in = 32'hFFFF_FFF8; eval_val_in = CMP_EQ;
    #1; chk("beq jflag", 32'(jump_flag_out), 1); chk("beq jaddr", jump_addr_out, 32'hF8);
    eval_val_in = CMP_LT;
    #1; chk("beq nt jflag", 32'(jump_flag_out), 0); chk("beq nt jaddr", jump_addr_out, CPU_RST_ADDRESS);
    func3_in = INST_FUNC3_BLT; immB_in = 32'h20;
    #1; chk("blt jaddr", jump_addr_out, 32'h120);
    func3_in = INST_FUNC3_BGEU;
    #1; chk("bgeu nt jflag", 32'(jump_flag_out), 0);
    eval_val_in = CMP_GT;
    #1; chk("bgeu jflag", 32'(jump_flag_out), 1);
    inst_addr_in = 32'hFFFF_FFF0;
    #1; chk("wrap jaddr", jump_addr_out, 32'h10);
    func3_in = INST_FUNC3_BNE; eval_val_in = CMP_EQ;
    #1; chk("bne nt jflag", 32'(jump_flag_out), 0);
    func3_in = INST_FUNC3_BEQ; flush_in = 1;
    #1; chk("flushed jflag", 32'(jump_flag_out), 0);
    flush_in = 0; push(0, 0, 0); tick(); check_wb("branch wb");

    clear_inputs();
    valid_in = 1; opcode_in = INST_JAL; inst_addr_in = 32'h200; immJ_in = 32'h40;
    eval_val_in = 32'h204; reg_write_addr_in = 5'd1; reg_we_in = 1;
    #1; chk("jal jflag", 32'(jump_flag_out), 1); chk("jal jaddr", jump_addr_out, 32'h240);
    push(1, 1, 32'h204); tick(); check_wb("jal link");

    run_md("mul",      INST_FUNC3_MUL,   32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD, 34);
    run_md("mulhu",    INST_FUNC3_MULHU, 32'hFFFF_FFFF, 32'd3,         32'h0000_0002, 34);
    run_md("mulh",     INST_FUNC3_MULH,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 34);
    run_md("div 7/0",  INST_FUNC3_DIV,   32'd7,         32'd0,         32'hFFFF_FFFF, 34);
    run_md("div -7/0", INST_FUNC3_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 34);
    run_md("rem 7/0",  INST_FUNC3_REM,   32'd7,         32'd0,         32'd7,         34);
    run_md("div ovf",  INST_FUNC3_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_md("rem ovf",  INST_FUNC3_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);
    run_md("div -7/2", INST_FUNC3_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run_md("rem -7/2", INST_FUNC3_REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run_md("divu",     INST_FUNC3_DIVU,  32'd100,       32'd7,         32'd14,        34);
    run_md("remu",     INST_FUNC3_REMU,  32'd100,       32'd7,         32'd2,         34);

    drive_md(INST_FUNC3_DIVU, 32'd100, 32'd7, 5'd12);
    tick();
    repeat (10) tick();
    flush_in = 1;
    push(0, 0, 0);
    tick();
    clear_inputs();
    #1;
    chk("flush busy", 32'(md_busy_out), 0);
    chk("flush hold", 32'(hold_flag_out), 0);
    check_wb("flush wb");
    writes = 0;
    repeat (40) begin
      tick();
      if (reg_we_out) writes++;
    end
    chk("flush no write", writes, 0);
    drive_alu(INST_TYPE_I, ALU_ADD, 32'h66, 5'd6, 1'b1); push(1, 6, 32'h66); tick(); check_wb("add after flush");

    drive_md(INST_FUNC3_MUL, 32'd5, 32'd6, 5'd13);
    tick();
    repeat (5) tick();
    clear_inputs();
    rst = 1; valid_in = 1; opcode_in = INST_JALR; inst_addr_in = 32'h300;
    reg1_data_in = 32'h1001; immI_in = 32'd2; eval_val_in = 32'h304;
    reg_write_addr_in = 5'd7; reg_we_in = 1;
    tick();
    chk("rst2 we", 32'(reg_we_out), 0);
    chk("rst2 addr", 32'(reg_write_addr_out), 0);
    chk("rst2 data", reg_write_data_out, 0);
    chk("rst2 busy", 32'(md_busy_out), 0);
    chk("rst2 hold", 32'(hold_flag_out), 0);
    rst = 0;
    #1;
    chk("jalr jflag", 32'(jump_flag_out), 1);
    chk("jalr jaddr", jump_addr_out, 32'h1002);
    push(1, 7, 32'h304); tick(); check_wb("jalr link");
    clear_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
